// File: rtl/eth_rmii_tx.sv
// RMII transmit framer: preamble/SFD, payload di-bits LSB pair first, then inter-packet gap.
// Define ETH_TX_CRC_EN to enable padding to MIN_LEN and the CRC-32 FCS append.
module eth_rmii_tx #(
  parameter int IPG_CYCLES = 48,
  parameter int MIN_LEN    = 60
) (
  input  logic       clk50,
  input  logic       rstn,
  input  logic [7:0] data,
  input  logic       valid,
  input  logic       last,
  output logic       ready,
  output logic       tx0,
  output logic       tx1,
  output logic       txen,
  output logic       busy,
  output logic       err
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PRE  = 3'd1;
  localparam logic [2:0] DATA = 3'd2;
  localparam logic [2:0] PAD  = 3'd3;
  localparam logic [2:0] FCS  = 3'd4;
  localparam logic [2:0] IPG  = 3'd5;

  localparam logic [15:0] IPG_LAST = 16'(IPG_CYCLES - 1);

  if (IPG_CYCLES < 48 || MIN_LEN < 0 || MIN_LEN > 2047) begin : g_param_check
    $error("eth_rmii_tx: IPG_CYCLES must be >= 48 and MIN_LEN within 0..2047");
  end

  logic [2:0]  state;
  logic [1:0]  phase;
  logic [15:0] cnt;
  logic [31:0] sh;
  logic        last_seen;
  logic        start;
  logic        take;
  logic        underrun;

`ifdef ETH_TX_CRC_EN
  localparam logic [10:0] MIN_LEN_B = 11'(MIN_LEN);

  logic [31:0] crc;
  logic [10:0] byte_cnt;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction
`endif

  // ready is only ever high on the last di-bit of a byte, so it doubles as the handshake slot
  assign take     = ready && valid;
  assign underrun = ready && !valid;
  assign start    = valid && ((state == IDLE) || (state == IPG && cnt == IPG_LAST));

  always_ff @(posedge clk50 or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      phase     <= 2'd0;
      cnt       <= 16'd0;
      sh        <= 32'd0;
      last_seen <= 1'b0;
      ready     <= 1'b0;
      tx0       <= 1'b0;
      tx1       <= 1'b0;
      txen      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
`ifdef ETH_TX_CRC_EN
      crc       <= 32'd0;
      byte_cnt  <= 11'd0;
`endif
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      if (take) begin
        state      <= DATA;
        {tx1, tx0} <= data[1:0];
        sh         <= {26'd0, data[7:2]};
        phase      <= 2'd0;
        last_seen  <= last;
`ifdef ETH_TX_CRC_EN
        crc        <= crc_step(crc, data[1:0]);
        if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
`endif
      end else if (underrun) begin
        state      <= IPG;
        txen       <= 1'b0;
        {tx1, tx0} <= 2'b00;
        err        <= 1'b1;
        cnt        <= 16'd0;
      end else begin
        case (state)
          PRE: begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'd30) begin
              {tx1, tx0} <= 2'b11;
              ready      <= 1'b1;
            end else begin
              {tx1, tx0} <= 2'b01;
            end
          end
          DATA, PAD: begin
            if (phase != 2'd3) begin
              {tx1, tx0} <= sh[1:0];
              sh         <= sh >> 2;
              phase      <= phase + 2'd1;
`ifdef ETH_TX_CRC_EN
              crc        <= crc_step(crc, sh[1:0]);
`endif
              if (state == DATA && phase == 2'd2 && !last_seen) ready <= 1'b1;
            end else begin
`ifdef ETH_TX_CRC_EN
              if (byte_cnt < MIN_LEN_B) begin
                state      <= PAD;
                {tx1, tx0} <= 2'b00;
                sh         <= 32'd0;
                phase      <= 2'd0;
                crc        <= crc_step(crc, 2'b00);
                if (byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
              end else begin
                state      <= FCS;
                {tx1, tx0} <= ~crc[1:0];
                sh         <= {2'b00, ~crc[31:2]};
                cnt        <= 16'd0;
              end
`else
              state      <= IPG;
              txen       <= 1'b0;
              {tx1, tx0} <= 2'b00;
              cnt        <= 16'd0;
`endif
            end
          end
          FCS: begin
            if (cnt == 16'd15) begin
              state      <= IPG;
              txen       <= 1'b0;
              {tx1, tx0} <= 2'b00;
              cnt        <= 16'd0;
            end else begin
              {tx1, tx0} <= sh[1:0];
              sh         <= sh >> 2;
              cnt        <= cnt + 16'd1;
            end
          end
          IPG: begin
            if (cnt == IPG_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
          IDLE: ;
          default: state <= IDLE;
        endcase
      end
      // a waiting source launches straight from the final gap clock so the gap stays exact
      if (start) begin
        state      <= PRE;
        txen       <= 1'b1;
        busy       <= 1'b1;
        {tx1, tx0} <= 2'b01;
        cnt        <= 16'd0;
        last_seen  <= 1'b0;
`ifdef ETH_TX_CRC_EN
        crc        <= 32'hFFFFFFFF;
        byte_cnt   <= 11'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_eth_rmii_tx.sv
// Scoreboard bench for eth_rmii_tx: expected di-bits are queued when a frame is driven
// and popped on every clock where txen is high.
module tb_eth_rmii_tx;

  logic       clk50 = 1'b0;
  logic       rstn  = 1'b1;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       last  = 1'b0;
  logic       ready, tx0, tx1, txen, busy, err;

  eth_rmii_tx dut (
    .clk50(clk50), .rstn(rstn), .data(data), .valid(valid), .last(last),
    .ready(ready), .tx0(tx0), .tx1(tx1), .txen(txen), .busy(busy), .err(err)
  );

  always #10 clk50 = ~clk50;

  int total = 0;
  int bad   = 0;

  logic [7:0] fd[$];
  bit         fl[$];
  logic [1:0] exp_q[$];
  int         gap_q[$];

  int txen_cnt, ready_cnt, err_cnt, tail_cnt, spacing_bad, idle_nz;

`ifdef ETH_TX_CRC_EN
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction
`endif

  task automatic push_byte(input logic [7:0] b);
    for (int k = 0; k < 4; k++) exp_q.push_back(b[2*k +: 2]);
  endtask

  // Queue preamble, SFD and the bytes the DUT should send; len is the expected txen-high count.
  task automatic push_frame(input int first, input int nsent, input bit complete, output int len);
`ifdef ETH_TX_CRC_EN
    logic [31:0] c;
`endif
    len = 32 + 4 * nsent;
    for (int i = 0; i < 31; i++) exp_q.push_back(2'b01);
    exp_q.push_back(2'b11);
    for (int i = 0; i < nsent; i++) push_byte(fd[first + i]);
`ifdef ETH_TX_CRC_EN
    if (complete) begin
      c = 32'hFFFFFFFF;
      for (int i = 0; i < nsent; i++) c = crc_byte(c, fd[first + i]);
      for (int i = nsent; i < 60; i++) begin
        push_byte(8'h00);
        c = crc_byte(c, 8'h00);
        len += 4;
      end
      c = ~c;
      for (int k = 0; k < 4; k++) push_byte(c[8*k +: 8]);
      len += 16;
    end
`else
    if (!complete) len = 32 + 4 * nsent;
`endif
  endtask

  // Drives fd/fl through the handshake and checks every transmitted di-bit until busy falls.
  task automatic run_frame(input int drop_at);
    int idx = 0;
    int cyc = 0;
    int last_ready = -1;
    int low_run = 0;
    bit took = 0, seen_busy = 0, prev_last = 1, was_high = 0;
    logic [1:0] e;
    txen_cnt = 0; ready_cnt = 0; err_cnt = 0; tail_cnt = 0; spacing_bad = 0; idle_nz = 0;
    gap_q.delete();
    data = fd[0]; last = fl[0]; valid = 1'b1;
    while (cyc < 4000) begin
      @(negedge clk50);
      cyc++;
      if (took) begin
        took = 0;
        idx++;
        if (idx < fd.size()) begin
          data = fd[idx]; last = fl[idx];
        end else begin
          valid = 1'b0; data = 8'h00; last = 1'b0;
        end
      end
      if (txen) begin
        if (was_high && low_run > 0) gap_q.push_back(low_run);
        low_run = 0;
        was_high = 1;
        txen_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL dibit: got %b with nothing expected", {tx1, tx0});
        end else begin
          e = exp_q.pop_front();
          if ({tx1, tx0} !== e) begin
            bad++;
            $display("[TB] FAIL dibit #%0d: got %b expected %b", txen_cnt, {tx1, tx0}, e);
          end
        end
      end else begin
        if ({tx1, tx0} !== 2'b00) idle_nz++;
        if (busy && was_high) low_run++;
      end
      if (err) err_cnt++;
      if (busy) seen_busy = 1;
      else if (seen_busy) break;
      if (ready) begin
        ready_cnt++;
        if (last_ready >= 0 && !prev_last && (cyc - last_ready) != 4) spacing_bad++;
        last_ready = cyc;
        if (ready_cnt == drop_at) begin
          valid = 1'b0;
          prev_last = 1;
        end else if (valid) begin
          took = 1;
          prev_last = fl[idx];
        end
      end
    end
    tail_cnt = low_run;
    valid = 1'b0;
    total++;
    if (cyc >= 4000) begin
      bad++;
      $display("[TB] FAIL frame_timeout: ran %0d clocks, required busy to fall", cyc);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL dibits_left: %0d unsent, required 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (idle_nz != 0) begin
      bad++;
      $display("[TB] FAIL idle_txd: %0d nonzero clocks with txen low, required 0", idle_nz);
    end
  endtask

  task automatic test_reset;
    #5 rstn = 1'b0;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
    total++; if (tx0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx0: got %b expected 0", tx0); end
    total++; if (tx1 !== 1'b0) begin bad++; $display("[TB] FAIL reset_tx1: got %b expected 0", tx1); end
    total++; if (txen !== 1'b0) begin bad++; $display("[TB] FAIL reset_txen: got %b expected 0", txen); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    repeat (3) @(negedge clk50);
    rstn = 1'b1;
    repeat (2) @(negedge clk50);
  endtask

  task automatic test_frame60;
    int len;
    fd.delete(); fl.delete();
    for (int i = 0; i < 60; i++) begin fd.push_back(8'(i)); fl.push_back(i == 59); end
    push_frame(0, 60, 1, len);
    run_frame(0);
`ifdef ETH_TX_CRC_EN
    total++; if (txen_cnt != 288) begin bad++; $display("[TB] FAIL f60_txen: got %0d expected 288", txen_cnt); end
`else
    total++; if (txen_cnt != 272) begin bad++; $display("[TB] FAIL f60_txen: got %0d expected 272", txen_cnt); end
`endif
    total++; if (txen_cnt != len) begin bad++; $display("[TB] FAIL f60_len: got %0d expected %0d", txen_cnt, len); end
    total++; if (ready_cnt != 60) begin bad++; $display("[TB] FAIL f60_ready: got %0d expected 60", ready_cnt); end
    total++; if (spacing_bad != 0) begin bad++; $display("[TB] FAIL f60_spacing: got %0d off-spacing pulses expected 0", spacing_bad); end
    total++; if (err_cnt != 0) begin bad++; $display("[TB] FAIL f60_err: got %0d expected 0", err_cnt); end
    total++; if (tail_cnt != 48) begin bad++; $display("[TB] FAIL f60_ipg: got %0d expected 48", tail_cnt); end
  endtask

  task automatic test_short_frame;
    int len;
    fd.delete(); fl.delete();
    fd.push_back(8'hFF); fl.push_back(1'b1);
    push_frame(0, 1, 1, len);
    run_frame(0);
`ifdef ETH_TX_CRC_EN
    total++; if (txen_cnt != 288) begin bad++; $display("[TB] FAIL short_txen: got %0d expected 288", txen_cnt); end
`else
    total++; if (txen_cnt != 36) begin bad++; $display("[TB] FAIL short_txen: got %0d expected 36", txen_cnt); end
`endif
    total++; if (ready_cnt != 1) begin bad++; $display("[TB] FAIL short_ready: got %0d expected 1", ready_cnt); end
  endtask

  task automatic test_random_frame;
    int len;
    fd.delete(); fl.delete();
    for (int i = 0; i < 17; i++) begin fd.push_back(8'($urandom_range(0, 255))); fl.push_back(i == 16); end
    push_frame(0, 17, 1, len);
    run_frame(0);
    total++; if (txen_cnt != len) begin bad++; $display("[TB] FAIL rand_txen: got %0d expected %0d", txen_cnt, len); end
    total++; if (ready_cnt != 17) begin bad++; $display("[TB] FAIL rand_ready: got %0d expected 17", ready_cnt); end
  endtask

  task automatic test_underrun;
    int len;
    fd.delete(); fl.delete();
    for (int i = 0; i < 10; i++) begin fd.push_back(8'(8'hA0 + i)); fl.push_back(i == 9); end
    push_frame(0, 4, 0, len);
    run_frame(5);
    total++; if (txen_cnt != 48) begin bad++; $display("[TB] FAIL under_txen: got %0d expected 48", txen_cnt); end
    total++; if (err_cnt != 1) begin bad++; $display("[TB] FAIL under_err: got %0d pulses expected 1", err_cnt); end
    total++; if (tail_cnt != 48) begin bad++; $display("[TB] FAIL under_busy: got %0d expected 48", tail_cnt); end
    total++; if (ready_cnt != 5) begin bad++; $display("[TB] FAIL under_ready: got %0d expected 5", ready_cnt); end
  endtask

  task automatic test_back_to_back;
    int len1, len2;
    fd.delete(); fl.delete();
    for (int i = 0; i < 8; i++) begin fd.push_back(8'($urandom_range(0, 255))); fl.push_back(i == 7); end
    for (int i = 0; i < 12; i++) begin fd.push_back(8'($urandom_range(0, 255))); fl.push_back(i == 11); end
    push_frame(0, 8, 1, len1);
    push_frame(8, 12, 1, len2);
    run_frame(0);
    total++; if (gap_q.size() != 1) begin bad++; $display("[TB] FAIL b2b_gaps: got %0d gaps expected 1", gap_q.size()); end
    else begin
      total++; if (gap_q[0] != 48) begin bad++; $display("[TB] FAIL b2b_gap: got %0d expected 48", gap_q[0]); end
    end
    total++; if (txen_cnt != len1 + len2) begin bad++; $display("[TB] FAIL b2b_txen: got %0d expected %0d", txen_cnt, len1 + len2); end
    total++; if (ready_cnt != 20) begin bad++; $display("[TB] FAIL b2b_ready: got %0d expected 20", ready_cnt); end
    total++; if (tail_cnt != 48) begin bad++; $display("[TB] FAIL b2b_ipg: got %0d expected 48", tail_cnt); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    int len;
    valid = 1'b1; data = 8'hA5; last = 1'b0;
    for (int c = 0; c < 400 && pulses < 3; c++) begin
      @(negedge clk50);
      if (ready) pulses++;
    end
    total++; if (pulses != 3) begin bad++; $display("[TB] FAIL rmid_reach: got %0d ready pulses expected 3", pulses); end
    #2 rstn = 1'b0;
    #1;
    total++; if (txen !== 1'b0) begin bad++; $display("[TB] FAIL rmid_txen: got %b expected 0", txen); end
    total++; if (ready !== 1'b0) begin bad++; $display("[TB] FAIL rmid_ready: got %b expected 0", ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rmid_busy: got %b expected 0", busy); end
    valid = 1'b0; data = 8'h00;
    repeat (3) @(negedge clk50);
    rstn = 1'b1;
    repeat (5) @(negedge clk50);
    total++; if ({busy, txen} !== 2'b00) begin bad++; $display("[TB] FAIL rmid_resume: got busy,txen=%b expected 00", {busy, txen}); end
    exp_q.delete();
    fd.delete(); fl.delete();
    fd.push_back(8'h12); fl.push_back(1'b0);
    fd.push_back(8'h34); fl.push_back(1'b0);
    fd.push_back(8'h56); fl.push_back(1'b1);
    push_frame(0, 3, 1, len);
    run_frame(0);
    total++; if (txen_cnt != len) begin bad++; $display("[TB] FAIL rmid_fresh: got %0d expected %0d", txen_cnt, len); end
  endtask

  initial begin
    $display("[TB] eth_rmii_tx bench start");
    test_reset();
    test_frame60();
    test_short_frame();
    test_random_frame();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
